fifo_port_arbiter: RTL

- Controller that wraps one MyFIFO-style instance (DEPTH entries × WIDTH bits, no status flags, registered read data).
- Arbitrates two producer streams onto the single FIFO write port using round-robin.
- Tracks occupancy so the FIFO is never overflowed and never read when empty.
- Presents the FIFO read side to one consumer as a valid/ready stream with throughput of 1 word/cycle.

---
 rtl/fifo_port_arbiter.sv | 98 +++++++++
 1 files changed

// File: rtl/fifo_port_arbiter.sv
// fifo_port_arbiter: round-robin merge of two producers into one MyFIFO.
// Optional stall counters enabled by defining FIFO_ARB_STATS_EN.
module fifo_port_arbiter #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             cons_valid,
  output logic [WIDTH-1:0] cons_data,
  input  logic             cons_ready,
  output logic             fifo_enable_write,
  output logic [WIDTH-1:0] fifo_value_to_write,
  output logic             fifo_enable_read,
  input  logic [WIDTH-1:0] fifo_value_to_read,
`ifdef FIFO_ARB_STATS_EN
  input  logic             clr_stats,
  output logic [15:0]      stall0_cnt,
  output logic [15:0]      stall1_cnt,
`endif
  output logic [CNT_W-1:0] fifo_count,
  output logic             fifo_full,
  output logic             fifo_empty
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  logic             ptr;
  logic             rd;
  logic             wr;
  logic             space;
  logic             grant0;
  logic             grant1;
  logic [CNT_W:0]   cnt_nx;

  // Read issue, space check and round-robin grant.
  always_comb begin
    rd     = !rst && (fifo_count != '0) && (!cons_valid || cons_ready);
    space  = (fifo_count < DEPTH_C) || rd;
    grant0 = !rst && space && req0_valid && (!req1_valid || !ptr);
    grant1 = !rst && space && req1_valid && (!req0_valid || ptr);
    wr     = grant0 || grant1;
    cnt_nx = {1'b0, fifo_count} + (CNT_W+1)'(wr) - (CNT_W+1)'(rd);
  end

  assign req0_ready          = grant0;
  assign req1_ready          = grant1;
  assign fifo_enable_write   = wr;
  assign fifo_value_to_write = grant1 ? req1_data : req0_data;
  assign fifo_enable_read    = rd;
  assign cons_data           = fifo_value_to_read;
  assign fifo_full           = (fifo_count == DEPTH_C);
  assign fifo_empty          = (fifo_count == '0);

  // Occupancy, output valid and fairness pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      fifo_count <= '0;
      cons_valid <= 1'b0;
      ptr        <= 1'b0;
    end else begin
      fifo_count <= cnt_nx[CNT_W-1:0];
      if (rd) begin
        cons_valid <= 1'b1;
      end else if (cons_ready) begin
        cons_valid <= 1'b0;
      end
      if (wr) begin
        ptr <= grant0;
      end
    end
  end

`ifdef FIFO_ARB_STATS_EN
  // Saturating per-producer stall counters; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr_stats) begin
      stall0_cnt <= '0;
      stall1_cnt <= '0;
    end else begin
      if (req0_valid && !grant0 && stall0_cnt != 16'hFFFF) begin
        stall0_cnt <= stall0_cnt + 16'd1;
      end
      if (req1_valid && !grant1 && stall1_cnt != 16'hFFFF) begin
        stall1_cnt <= stall1_cnt + 16'd1;
      end
    end
  end
`endif

endmodule
